// File: rtl/fetch_frontend.sv
// Instruction-fetch front end: owns the PC, pipelines word fetches and buffers {instr, pc} for decode.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_frontend #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            misalign_err
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [CntW:0] InflightMax = (CntW + 1)'(FIFO_DEPTH);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {StIdle, StFetch, StErr} state_e;
`else
  typedef enum logic [0:0] {StIdle, StFetch} state_e;
`endif

  state_e            r_state;
  state_e            w_state_next;
  logic [XLEN-1:0]   r_pc;
  logic [CntW-1:0]   r_outstanding;
  logic [CntW-1:0]   r_fifo_count;
  logic [CntW-1:0]   r_drop_cnt;
  logic [CntW-1:0]   w_outstanding_next;
  logic [CntW-1:0]   w_fifo_count_next;
  logic [CntW-1:0]   w_drop_cnt_next;
  logic [PtrW-1:0]   r_fifo_wptr;
  logic [PtrW-1:0]   r_fifo_rptr;
  logic [PtrW-1:0]   r_tag_wptr;
  logic [PtrW-1:0]   r_tag_rptr;
  logic [XLEN-1:0]   r_fifo_instr [FIFO_DEPTH];
  logic [XLEN-1:0]   r_fifo_pc    [FIFO_DEPTH];
  logic [XLEN-1:0]   r_tag_pc     [FIFO_DEPTH];

  logic [CntW:0]     w_inflight;
  logic              w_credit;
  logic              w_req_valid;
  logic              w_fire;
  logic              w_push;
  logic              w_if_valid;
  logic              w_pop;
  logic [XLEN-1:0]   w_redirect_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misalign;
  logic w_misalign_next;
  logic w_misaligned;
  assign w_misaligned  = redirect_pc[1:0] != 2'b00;
  assign w_redirect_pc = redirect_pc;
  assign misalign_err  = r_misalign;
`else
  logic w_unused_pc_lsb;
  assign w_unused_pc_lsb = ^redirect_pc[1:0];
  assign w_redirect_pc   = {redirect_pc[XLEN-1:2], 2'b00};
  assign misalign_err    = 1'b0;
`endif

  // Dropped-but-pending responses are still counted in r_outstanding, so credit covers them.
  assign w_inflight  = {1'b0, r_outstanding} + {1'b0, r_fifo_count};
  assign w_credit    = w_inflight < InflightMax;
  assign w_req_valid = (r_state == StFetch) && w_credit && !redirect;
  assign w_fire      = w_req_valid && imem_req_ready;
  assign w_push      = imem_resp_valid && (r_drop_cnt == '0) && !redirect;
  assign w_if_valid  = (r_fifo_count != '0) && !redirect;
  assign w_pop       = w_if_valid && if_ready;

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign if_valid       = w_if_valid;
  assign if_instr       = r_fifo_instr[r_fifo_rptr];
  assign if_pc          = r_fifo_pc[r_fifo_rptr];

  always_comb begin
    w_state_next = r_state;
`ifdef FETCH_MISALIGN_CHECK_EN
    w_misalign_next = r_misalign;
`endif
    if (r_state == StIdle) w_state_next = StFetch;
    if (redirect) begin
`ifdef FETCH_MISALIGN_CHECK_EN
      w_state_next    = w_misaligned ? StErr : StFetch;
      w_misalign_next = w_misaligned;
`else
      w_state_next = StFetch;
`endif
    end
  end

  always_comb begin
    w_outstanding_next = r_outstanding + CntW'(w_fire) - CntW'(imem_resp_valid);
    w_fifo_count_next  = r_fifo_count + CntW'(w_push) - CntW'(w_pop);
    w_drop_cnt_next    = r_drop_cnt;
    if (redirect) begin
      // Everything still in flight after this edge belongs to the abandoned path.
      w_fifo_count_next = '0;
      w_drop_cnt_next   = w_outstanding_next;
    end else if (imem_resp_valid && (r_drop_cnt != '0)) begin
      w_drop_cnt_next = r_drop_cnt - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_fifo_count  <= '0;
      r_drop_cnt    <= '0;
      r_fifo_wptr   <= '0;
      r_fifo_rptr   <= '0;
      r_tag_wptr    <= '0;
      r_tag_rptr    <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      r_misalign    <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_outstanding_next;
      r_fifo_count  <= w_fifo_count_next;
      r_drop_cnt    <= w_drop_cnt_next;
`ifdef FETCH_MISALIGN_CHECK_EN
      r_misalign    <= w_misalign_next;
`endif
      if (redirect) begin
        r_pc        <= w_redirect_pc;
        r_fifo_rptr <= r_fifo_wptr;
        r_tag_rptr  <= r_tag_wptr;
      end else begin
        if (w_fire) begin
          r_pc       <= r_pc + XLEN'(4);
          r_tag_wptr <= r_tag_wptr + PtrW'(1);
        end
        if (w_push) begin
          r_fifo_wptr <= r_fifo_wptr + PtrW'(1);
          r_tag_rptr  <= r_tag_rptr + PtrW'(1);
        end
        if (w_pop) r_fifo_rptr <= r_fifo_rptr + PtrW'(1);
      end
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (w_fire) r_tag_pc[r_tag_wptr] <= r_pc;
    if (w_push) begin
      r_fifo_instr[r_fifo_wptr] <= imem_resp_data;
      r_fifo_pc[r_fifo_wptr]    <= r_tag_pc[r_tag_rptr];
    end
  end

endmodule

// File: tb/tb_fetch_frontend.sv
// Self-checking bench for fetch_frontend: fixed-latency in-order memory model plus a
// program-order reference for request addresses and delivered {pc, instr} pairs.
module tb_fetch_frontend;

  localparam logic [31:0] RstPc = 32'hFFFF_FFF8;
  localparam int          Depth = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        misalign_err;

  always #5 clk = ~clk;

  fetch_frontend #(
    .XLEN      (32),
    .RESET_PC  (RstPc),
    .FIFO_DEPTH(Depth)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .misalign_err   (misalign_err)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc;
  int          lat;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] exp_req;
  logic [31:0] exp_pop;
  bit          m_err;
  int          n_fire;
  int          n_pop;
  int          first_pop_cyc;
  logic [31:0] first_fire_addr;
  bit          prev_stall;
  logic [31:0] prev_addr;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] tgt_pc(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHECK_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  // One clock cycle: drive memory response, check outputs mid-cycle, advance the models.
  task automatic tick();
    logic fire;
    logic pop;
    if (q_due.size() != 0 && q_due[0] == cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = instr_of(q_addr[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    #1;
    fire = imem_req_valid && imem_req_ready;
    pop  = if_valid && if_ready;
    n_checks++;
    if (misalign_err !== m_err) begin
      n_fail++;
      $display("FAIL misalign_err cyc=%0d: got %b want %b", cyc, misalign_err, m_err);
    end
    if (prev_stall && !redirect) begin
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
        n_fail++;
        $display("FAIL req_hold cyc=%0d: got valid=%b addr=%h want valid=1 addr=%h",
                 cyc, imem_req_valid, imem_req_addr, prev_addr);
      end
    end
    if (redirect) begin
      n_checks++;
      if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL redirect_quiet cyc=%0d: got req_valid=%b if_valid=%b want 0 0",
                 cyc, imem_req_valid, if_valid);
      end
    end
    n_checks++;
    if (q_due.size() > Depth) begin
      n_fail++;
      $display("FAIL outstanding cyc=%0d: got %0d want <=%0d", cyc, q_due.size(), Depth);
    end
    if (fire) begin
      n_checks++;
      if (m_err || imem_req_addr !== exp_req) begin
        n_fail++;
        $display("FAIL req_addr cyc=%0d: got %h want %h (err_state=%b)",
                 cyc, imem_req_addr, exp_req, m_err);
      end
      if (n_fire == 0) first_fire_addr = imem_req_addr;
      q_addr.push_back(imem_req_addr);
      q_due.push_back(cyc + lat);
      exp_req = exp_req + 32'd4;
      n_fire++;
    end
    if (pop) begin
      n_checks++;
      if (if_pc !== exp_pop || if_instr !== instr_of(exp_pop)) begin
        n_fail++;
        $display("FAIL pop cyc=%0d: got pc=%h instr=%h want pc=%h instr=%h",
                 cyc, if_pc, if_instr, exp_pop, instr_of(exp_pop));
      end
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      exp_pop = exp_pop + 32'd4;
      n_pop++;
    end
    prev_stall = imem_req_valid && !imem_req_ready && !redirect;
    prev_addr  = imem_req_addr;
    if (imem_resp_valid) begin
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end
    if (redirect) begin
`ifdef FETCH_MISALIGN_CHECK_EN
      m_err = (redirect_pc[1:0] != 2'b00);
`endif
      exp_req = tgt_pc(redirect_pc);
      exp_pop = exp_req;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int latency);
    reset           = 1'b1;
    redirect        = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b0;
    if_ready        = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || misalign_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req_valid=%b if_valid=%b err=%b want 0 0 0",
               imem_req_valid, if_valid, misalign_err);
    end
    n_checks++;
    if (imem_req_addr !== RstPc) begin
      n_fail++;
      $display("FAIL reset_pc: got %h want %h", imem_req_addr, RstPc);
    end
    q_addr.delete();
    q_due.delete();
    lat           = latency;
    cyc           = 0;
    exp_req       = RstPc;
    exp_pop       = RstPc;
    m_err         = 1'b0;
    prev_stall    = 1'b0;
    n_fire        = 0;
    n_pop         = 0;
    first_pop_cyc = -1;
    reset         = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1);
    tick();
    n_checks++;
    if (n_fire != 0) begin
      n_fail++;
      $display("FAIL idle_cycle: got fires=%0d want 0", n_fire);
    end
  endtask

  // Peak throughput, including the FFFF_FFFC -> 0 wrap.
  task automatic test_stream();
    do_reset(1);
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    repeat (20) tick();
    n_checks++;
    if (first_pop_cyc != 3) begin
      n_fail++;
      $display("FAIL first_if_valid: got cyc %0d want 3", first_pop_cyc);
    end
    n_checks++;
    if (n_fire != 19 || n_pop != 17) begin
      n_fail++;
      $display("FAIL stream_rate: got fires=%0d pops=%0d want 19 17", n_fire, n_pop);
    end
  endtask

  task automatic test_backpressure();
    do_reset(1);
    imem_req_ready = 1'b1;
    if_ready       = 1'b0;
    repeat (12) tick();
    n_checks++;
    if (n_fire != Depth || imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_cap: got fires=%0d req_valid=%b want %0d 0",
               n_fire, imem_req_valid, Depth);
    end
    if_ready = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (n_pop != 10 || n_fire != 13) begin
      n_fail++;
      $display("FAIL drain_resume: got pops=%0d fires=%0d want 10 13", n_pop, n_fire);
    end
  endtask

  task automatic test_redirect_drop();
    int r;
    do_reset(3);
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    for (int i = 0; i < 10 && q_due.size() < 2; i++) tick();
    n_checks++;
    if (q_due.size() != 2) begin
      n_fail++;
      $display("FAIL setup_outstanding: got %0d want 2", q_due.size());
    end
    r             = cyc;
    n_pop         = 0;
    first_pop_cyc = -1;
    redirect      = 1'b1;
    redirect_pc   = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    repeat (12) tick();
    n_checks++;
    if (first_pop_cyc != r + 5 || n_pop == 0) begin
      n_fail++;
      $display("FAIL redirect_latency: got first pop cyc %0d pops=%0d want cyc %0d",
               first_pop_cyc, n_pop, r + 5);
    end
  endtask

  task automatic test_ready_toggle();
    do_reset(1);
    if_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      imem_req_ready = (i % 2 == 0);
      tick();
    end
    n_checks++;
    if (n_fire != 11) begin
      n_fail++;
      $display("FAIL toggle_fires: got %0d want 11", n_fire);
    end
  endtask

  task automatic test_misalign();
    do_reset(1);
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    repeat (4) tick();
    n_fire      = 0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    repeat (6) tick();
`ifdef FETCH_MISALIGN_CHECK_EN
    n_checks++;
    if (n_fire != 0 || misalign_err !== 1'b1) begin
      n_fail++;
      $display("FAIL misalign_trap: got fires=%0d err=%b want 0 1", n_fire, misalign_err);
    end
`else
    n_checks++;
    if (n_fire == 0 || first_fire_addr !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL misalign_ignored: got fires=%0d addr=%h want >0 00000100",
               n_fire, first_fire_addr);
    end
`endif
    n_fire      = 0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    repeat (6) tick();
    n_checks++;
    if (n_fire == 0 || first_fire_addr !== 32'h0000_0200 || misalign_err !== 1'b0) begin
      n_fail++;
      $display("FAIL aligned_recover: got fires=%0d addr=%h err=%b want >0 00000200 0",
               n_fire, first_fire_addr, misalign_err);
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 3; round++) begin
      do_reset(1 + round);
      for (int i = 0; i < 400; i++) begin
        imem_req_ready = ($urandom_range(0, 3) != 0);
        if_ready       = ($urandom_range(0, 2) != 0);
        redirect       = ($urandom_range(0, 19) == 0);
`ifdef FETCH_MISALIGN_CHECK_EN
        redirect_pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
`else
        redirect_pc = $urandom;
`endif
        tick();
      end
      redirect = 1'b0;
      n_checks++;
      if (n_pop == 0) begin
        n_fail++;
        $display("FAIL random_progress round=%0d: got pops=0 want >0", round);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_ready_toggle();
    test_misalign();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no completion want finish before 1000000");
    $fatal(1);
  end

endmodule

// File: doc/fetch_frontend.md
# fetch_frontend

Parametrised instruction-fetch front end for the RISC-V core: owns the PC, issues word fetches to instruction memory over a valid/ready request channel, buffers in-order responses in a FIFO, and presents {instr, pc} pairs to the decoder with a valid/ready handshake. It replaces the bare PC register plus direct instruction wire between fetch and decode, adding backpressure, multiple outstanding fetches and redirect (branch/jump) flushing.

## Interface
- XLEN, 32, PC/address and instruction width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- FIFO_DEPTH, 4, instruction buffer entries (power of two, >=2); also cap on fetches in flight plus buffered
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- redirect  input  1  jump/branch taken; load redirect_pc and flush
- redirect_pc  input  XLEN  redirect target
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  XLEN  fetch address (current PC)
- imem_resp_valid  input  1  one-cycle response pulse, in request order, no backpressure
- imem_resp_data  input  XLEN  fetched instruction
- if_valid  output  1  decoder-side instruction valid
- if_ready  input  1  decoder accepts
- if_instr  output  XLEN  instruction at FIFO head
- if_pc  output  XLEN  PC of that instruction
- misalign_err  output  1  sticky misaligned-redirect flag (0 when macro undefined)

## Operation
- State: IDLE, FETCH, ERR. reset -> IDLE; IDLE -> FETCH next cycle unconditionally; ERR only with FETCH_MISALIGN_CHECK_EN.
- Credit: outstanding (issued, not yet responded) + fifo_count < FIFO_DEPTH. Counters $clog2(FIFO_DEPTH+1) bits; never exceed FIFO_DEPTH.
- imem_req_valid = (state==FETCH) && credit && !redirect (combinational). imem_req_addr = pc.
- Request fire (valid && ready): pc <= pc + 4 (mod 2^XLEN; 32'hFFFF_FFFC wraps to 0), outstanding increments. While valid && !ready, addr held stable.
- Response: outstanding decrements; if drop_cnt > 0, data discarded and drop_cnt decrements; else {data, pc_of_that_fetch} pushed at FIFO tail. PC tags held in a parallel tag queue captured at issue.
- if_valid = fifo_count != 0 && !redirect; pop on if_valid && if_ready. Simultaneous push and pop: count unchanged.
- Redirect cycle: no issue, no pop; next edge pc <= redirect_pc, FIFO and tag queue emptied, drop_cnt <= outstanding minus 1 if imem_resp_valid this cycle (that response also dropped). Redirect while drop_cnt>0 adds to it equivalently (drop_cnt <= total outstanding after this cycle).
- Redirect during IDLE: accepted, pc loaded, state still advances to FETCH.
- Reset mid-operation overrides everything; outstanding responses arriving after reset are ignored only if the memory is also reset (integration requirement).

## Timing
- Reset values: pc=RESET_PC, state=IDLE, imem_req_valid=0, if_valid=0, fifo_count=0, outstanding=0, drop_cnt=0, misalign_err=0; if_instr/if_pc don't-care while if_valid=0.
- First request: second cycle after reset deasserts (one IDLE cycle).
- Response to if_valid: 1 cycle (registered FIFO, no bypass).
- Redirect to first request at new PC: next cycle. Redirect to first if_valid of new path: 1 cycle after its response.
- Peak throughput one instruction per cycle with single-cycle memory and FIFO_DEPTH>=2.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0] != 0 sets misalign_err (sticky) and moves to ERR; ERR issues no requests, still drops/drains as normal; aligned redirect clears misalign_err and returns to FETCH; reset clears.
- Undefined: redirect_pc[1:0] ignored (pc low bits forced 00), misalign_err tied 0, no ERR state.

## Test plan
- Reset, imem_req_ready=1, 1-cycle memory, if_ready=1 -> addrs 0,4,8,... one per cycle; if_pc/if_instr match in order, first if_valid 3 cycles after reset release.
- if_ready=0, FIFO_DEPTH=4 -> exactly 4 fetches accepted, imem_req_valid drops; release if_ready -> 4 pops then fetching resumes at 0x10.
- 3-cycle memory latency, redirect to 0x100 with 2 fetches outstanding -> both responses dropped, next if_pc=0x100, no stale instruction visible.
- imem_req_ready toggling 1/0 with valid held -> addr stable across stall, no duplicate or skipped PCs.
- RESET_PC=32'hFFFF_FFF8 -> fetch sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Macro defined: redirect to 0x102 -> misalign_err=1, no requests; redirect to 0x200 -> misalign_err=0, fetch at 0x200; macro undefined: same redirect fetches 0x100.
